// File: rtl/multdiv_sequencer.sv
// Sequencer shared by the radix-4 Booth multiplier and the iterative divider: latches
// operands, drives load/step enables, counts iterations and returns one registered result.
module multdiv_sequencer #(
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [31:0]      operand_a,
  input  logic [31:0]      operand_b,
  input  logic [TAG_W-1:0] dest_tag,
  output logic [31:0]      op_a_q,
  output logic [31:0]      op_b_q,
  output logic             mult_load,
  output logic             mult_en,
  input  logic [31:0]      mult_result,
  input  logic             mult_ovf,
  output logic             div_load,
  output logic             div_en,
  input  logic [31:0]      div_quotient,
  output logic             stall,
  output logic             result_rdy,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] result_tag,
  output logic             exception
);

  localparam int CNT_W = $clog2(DIV_STEPS + 1);

  typedef enum logic [2:0] {IDLE, MLOAD, MRUN, DLOAD, DRUN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] step_cnt;
  logic [TAG_W-1:0] tag_q;
  logic             start;
  logic             div_by_zero;
  logic             mult_last;
  logic             div_last;

  assign start       = ctrl_mult | ctrl_div;
  assign div_by_zero = ctrl_div & ~ctrl_mult & (operand_b == 32'd0);
  assign mult_last   = (step_cnt == CNT_W'(MULT_STEPS - 1));
  assign div_last    = (step_cnt == CNT_W'(DIV_STEPS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A new ctrl pulse overrides whatever the current state would do next,
  // which is how an in-flight op gets aborted without a result.
  always_comb begin
    state_next = state;
    mult_load  = 1'b0;
    mult_en    = 1'b0;
    div_load   = 1'b0;
    div_en     = 1'b0;
    stall      = 1'b0;
    result_rdy = 1'b0;
    case (state)
      IDLE: ;
      MLOAD: begin
        mult_load  = 1'b1;
        stall      = 1'b1;
        state_next = MRUN;
      end
      MRUN: begin
        mult_en = 1'b1;
        stall   = 1'b1;
        if (mult_last) state_next = DONE;
      end
      DLOAD: begin
        div_load   = 1'b1;
        stall      = 1'b1;
        state_next = DRUN;
      end
      DRUN: begin
        div_en = 1'b1;
        stall  = 1'b1;
        if (div_last) state_next = DONE;
      end
      DONE: begin
        result_rdy = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (ctrl_mult)     state_next = MLOAD;
    else if (ctrl_div) state_next = (operand_b != 32'd0) ? DLOAD : DONE;
  end

  // Operand/tag capture, step counting and result capture on the final step edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      tag_q      <= '0;
      step_cnt   <= '0;
      result     <= '0;
      result_tag <= '0;
      exception  <= 1'b0;
    end else if (start) begin
      op_a_q   <= operand_a;
      op_b_q   <= operand_b;
      tag_q    <= dest_tag;
      step_cnt <= '0;
      if (div_by_zero) begin
        result     <= '0;
        result_tag <= dest_tag;
        exception  <= 1'b1;
      end
    end else begin
      if (state == MRUN || state == DRUN) step_cnt <= step_cnt + CNT_W'(1);
      if (state == MRUN && mult_last) begin
        result     <= mult_result;
        result_tag <= tag_q;
        exception  <= mult_ovf;
      end
      if (state == DRUN && div_last) begin
        result     <= div_quotient;
        result_tag <= tag_q;
        exception  <= 1'b0;
      end
    end
  end

endmodule
